// File: rtl/alu_exec_unit.sv
// Single-lane ALU execution unit: one-cycle ADD/SUB/ADDI/CMP, iterative shift-add MUL,
// valid/ready request and response handshakes with a registered, back-pressure-safe response.
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_CMP  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
endpackage

module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int TAG_WIDTH          = 4,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_opcode,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_cmp_flag,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_illegal,
  output logic                  busy
);
  localparam int N  = DATA_WIDTH / MUL_BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mcand, mplier, acc, partial, acc_sum;
  logic [CW-1:0]         iter;
  logic [TAG_WIDTH-1:0]  mul_tag;
  logic                  accept, is_mul, rsp_free, last_iter, mul_done;
  logic [DATA_WIDTH-1:0] op_result;
  logic                  op_flag, op_illegal;

  assign accept    = req_valid && req_ready;
  assign is_mul    = (req_opcode == OP_MUL);
  assign rsp_free  = !rsp_valid || rsp_ready;
  assign last_iter = (iter == CW'(N - 1));
  // The final iteration only retires when the output register can take the product.
  assign mul_done  = (state == MUL) && last_iter && rsp_free;
  assign partial   = mcand * DATA_WIDTH'(mplier[MUL_BITS_PER_CYCLE-1:0]);
  assign acc_sum   = acc + partial;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mul) state_nxt = MUL;
      MUL:     if (mul_done)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == MUL);
    req_ready = (state == IDLE) && rsp_free;
  end

  // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
  always_comb begin
    op_result  = '0;
    op_flag    = 1'b0;
    op_illegal = 1'b0;
    case (req_opcode)
      OP_ADD, OP_ADDI: op_result = req_a + req_b;
      OP_SUB:          op_result = req_a - req_b;
      OP_CMP: begin
        op_result = req_a - req_b;
        op_flag   = (req_a < req_b);
      end
      OP_MUL:          op_result = '0;
      default:         op_illegal = 1'b1;
    endcase
  end

  // NOTE: the multiplier datapath is reset too, so an aborted multiply leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      iter    <= '0;
      mul_tag <= '0;
    end else if (accept && is_mul) begin
      mcand   <= req_a;
      mplier  <= req_b;
      acc     <= '0;
      iter    <= '0;
      mul_tag <= req_tag;
    end else if (state == MUL && !last_iter) begin
      acc    <= acc_sum;
      mcand  <= mcand << MUL_BITS_PER_CYCLE;
      mplier <= mplier >> MUL_BITS_PER_CYCLE;
      iter   <= iter + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_cmp_flag <= 1'b0;
      rsp_tag      <= '0;
      rsp_illegal  <= 1'b0;
    end else if (accept && !is_mul) begin
      rsp_valid    <= 1'b1;
      rsp_result   <= op_result;
      rsp_cmp_flag <= op_flag;
      rsp_tag      <= req_tag;
      rsp_illegal  <= op_illegal;
    end else if (mul_done) begin
      rsp_valid    <= 1'b1;
      rsp_result   <= acc_sum;
      rsp_cmp_flag <= 1'b0;
      rsp_tag      <= mul_tag;
      rsp_illegal  <= 1'b0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors, hand-computed expectations,
// and a cycle-by-cycle comparison against a behavioural model of the lane's handshake rules.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_opcode = '0;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [TW-1:0] req_tag = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_result;
  logic          rsp_cmp_flag;
  logic [TW-1:0] rsp_tag;
  logic          rsp_illegal;
  logic          busy;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .MUL_BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cmp_flag(rsp_cmp_flag), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the writeback stage should see, from the lane's rules.
  logic          m_busy, m_val, m_flag, m_ill;
  int            m_cnt;
  logic [DW-1:0] m_res, m_mres;
  logic [TW-1:0] m_tag, m_mtag;

  always @(posedge clk or negedge rst_n) begin : model
    logic free, loaded;
    if (!rst_n) begin
      m_busy = 0; m_val = 0; m_flag = 0; m_ill = 0; m_cnt = 0;
      m_res = '0; m_mres = '0; m_tag = '0; m_mtag = '0;
    end else begin
      free   = !m_val || rsp_ready;
      loaded = 0;
      if (m_busy) begin
        if (m_cnt > 1) m_cnt--;
        else if (free) begin
          m_val = 1; m_res = m_mres; m_flag = 0; m_tag = m_mtag; m_ill = 0;
          m_busy = 0; loaded = 1;
        end
      end else if (req_valid && free) begin
        if (req_opcode == OP_MUL) begin
          m_busy = 1; m_cnt = N; m_mres = req_a * req_b; m_mtag = req_tag;
        end else begin
          loaded = 1; m_val = 1; m_tag = req_tag; m_flag = 0; m_ill = 0;
          case (req_opcode)
            OP_ADD, OP_ADDI: m_res = req_a + req_b;
            OP_SUB:          m_res = req_a - req_b;
            OP_CMP: begin m_res = req_a - req_b; m_flag = (req_a < req_b); end
            default: begin m_res = '0; m_ill = 1; end
          endcase
        end
      end
      if (!loaded && rsp_ready) m_val = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("mdl_rsp_valid", rsp_valid, m_val);
      check("mdl_busy", busy, m_busy);
      check("mdl_req_ready", req_ready, !m_busy && (!m_val || rsp_ready));
      if (m_val) begin
        check("mdl_result", rsp_result, m_res);
        check("mdl_cmp_flag", rsp_cmp_flag, m_flag);
        check("mdl_tag", rsp_tag, m_tag);
        check("mdl_illegal", rsp_illegal, m_ill);
      end
    end
  end

  // Optional back-pressure pattern on rsp_ready, applied at negedges.
  logic        bp_en = 1'b0;
  logic [15:0] bp_pat = 16'b1011_0010_1101_0110;
  int          bp_cyc = 0;
  always @(negedge clk) begin
    if (bp_en) begin
      rsp_ready = bp_pat[bp_cyc % 16];
      bp_cyc++;
    end
  end

  // Drive a request and return just after the edge that accepted it.
  task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] tag);
    bit ok = 0;
    @(negedge clk);
    req_valid = 1; req_opcode = op; req_a = a; req_b = b; req_tag = tag;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("send_timeout", 0, 1);
    else     @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 0;
  endtask

  initial begin
    int cnt;
    int seen;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", rsp_result, 0);
    check("rst_tag_ill_flag", {rsp_tag, rsp_illegal, rsp_cmp_flag}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // 1: ADD
    send(OP_ADD, 5, 3, 1);
    #1;
    check("add_valid", rsp_valid, 1);
    check("add_result", rsp_result, 32'h8);
    check("add_flag_tag", {rsp_cmp_flag, rsp_tag}, {1'b0, 4'd1});

    // 2: SUB then CMP back-to-back
    send(OP_SUB, 3, 5, 2);
    #1;
    check("sub_result", rsp_result, 32'hFFFF_FFFE);
    check("sub_flag", rsp_cmp_flag, 0);
    send(OP_CMP, 3, 5, 3);
    #1;
    check("cmp_result", rsp_result, 32'hFFFF_FFFE);
    check("cmp_flag", rsp_cmp_flag, 1);
    idle();

    // 3: MUL latency and result
    send(OP_MUL, 5, 3, 4);
    idle();
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
    end while (!rsp_valid && cnt < 40);
    check("mul_latency", cnt, N);
    check("mul_result", rsp_result, 32'hF);
    check("mul_tag", rsp_tag, 4);
    send(OP_MUL, 32'hFFFF_FFFF, 2, 5);
    idle();
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
    end while (!rsp_valid && cnt < 40);
    check("mul_wrap_result", rsp_result, 32'hFFFF_FFFE);
    repeat (2) @(negedge clk);

    // 4: response held under back-pressure
    @(negedge clk);
    rsp_ready = 0;
    send(OP_ADD, 32'h10, 32'h2, 6);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_result", rsp_result, 32'h12);
      check("hold_ready", req_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1;
    @(posedge clk); #1;
    check("hold_release", rsp_valid, 0);

    // 5: reset during a multiply
    send(OP_MUL, 7, 9, 7);
    idle();
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("midrst_outputs", {rsp_valid, busy, rsp_illegal, rsp_cmp_flag, rsp_tag}, 0);
    check("midrst_result", rsp_result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    send(OP_ADD, 1, 1, 8);
    #1;
    check("post_rst_add", rsp_result, 32'h2);

    // 6: illegal opcode
    send(4'hF, 7, 7, 9);
    #1;
    check("ill_flags", {rsp_valid, rsp_illegal, rsp_cmp_flag}, 3'b110);
    check("ill_result", rsp_result, 0);
    idle();

    // Mixed traffic under a back-pressure pattern; the model covers every cycle.
    bp_en = 1;
    send(OP_ADDI, 32'hFFFF_FFFF, 1, 1);
    send(OP_CMP, 9, 4, 2);
    send(OP_SUB, 0, 1, 3);
    send(OP_CMP, 32'h8000_0000, 32'h8000_0001, 4);
    send(4'h9, 1, 2, 5);
    send(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 6);
    send(OP_ADD, 32'hDEAD_0000, 32'h0000_BEEF, 7);
    send(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8);
    send(OP_CMP, 4, 4, 9);
    idle();
    repeat (40) @(posedge clk);
    bp_en = 0;
    @(negedge clk);
    rsp_ready = 1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end
endmodule
